// File: rtl/fnd_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// fnd_pkg: shared types and constants for the FND scan controller. Rev 1.0
// ------------------------------------------------------------------------
package fnd_pkg;

  typedef enum logic [0:0] {
    ST_DEAD = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  localparam logic [3:0] POS_OFF = 4'b1111;
  localparam logic [3:0] POS_D0  = 4'b1110;
  localparam logic [3:0] POS_D1  = 4'b1101;
  localparam logic [3:0] POS_D2  = 4'b1011;
  localparam logic [3:0] POS_D3  = 4'b0111;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0-9 and A,b,C,d,E,F
  localparam logic [6:0] GLYPH_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [3:0] pos_code(input logic [1:0] digit);
    case (digit)
      2'd0:    return POS_D0;
      2'd1:    return POS_D1;
      2'd2:    return POS_D2;
      default: return POS_D3;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_seg_decoder.sv
`default_nettype none
// ------------------------------------------------------------------------
// fnd_seg_decoder: nibble to active-low 7-segment glyph. Rev 1.0
// ------------------------------------------------------------------------
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_glyph
);

  assign o_glyph = GLYPH_TBL[i_nibble];

endmodule
`default_nettype wire

// File: rtl/fnd_scan_controller.sv
`default_nettype none
// ------------------------------------------------------------------------
// fnd_scan_controller: 4-digit FND scan with dead-time and LZ blanking. Rev 1.0
// ------------------------------------------------------------------------
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int P_TICK_DIV = 100_000,
  parameter int P_DEAD_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_bcd,
  input  logic [3:0]  i_dp,
  input  logic        i_load,
  input  logic        i_lz_blank,
  output logic [3:0]  o_position,
  output logic [7:0]  o_segment,
  output logic [1:0]  o_digit,
  output logic        o_frame_done
);

  localparam int            CW          = $clog2(P_TICK_DIV);
  localparam logic [CW-1:0] C_DEAD_LAST = CW'(P_DEAD_CYC - 1);
  localparam logic [CW-1:0] C_SLOT_LAST = CW'(P_TICK_DIV - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [19:0]   r_pending;
  logic [19:0]   r_display;
  logic [1:0]    r_digit;
  logic [3:0]    r_position;
  logic [7:0]    r_segment;
  logic          r_frame_done;

  logic          w_enter_show;
  logic          w_end_show;
  logic [CW-1:0] w_cnt_inc;
  logic [19:0]   w_disp;
  logic [3:0]    w_nibble;
  logic          w_dp;
  logic          w_upper_zero;
  logic [6:0]    w_glyph;
  logic [7:0]    w_seg;

  assign w_enter_show = (r_state == ST_DEAD) && (r_cnt == C_DEAD_LAST);
  assign w_end_show   = (r_state == ST_SHOW) && (r_cnt == C_SLOT_LAST);
  assign w_cnt_inc    = r_cnt + 1'b1;
  // The segment computed on the commit edge must already use the value being committed
  assign w_disp       = w_enter_show ? r_pending : r_display;

  always_comb begin
    w_nibble     = w_disp[3:0];
    w_dp         = w_disp[16];
    w_upper_zero = 1'b0;
    case (r_digit)
      2'd1: begin
        w_nibble     = w_disp[7:4];
        w_dp         = w_disp[17];
        w_upper_zero = (w_disp[15:4] == 12'h000);
      end
      2'd2: begin
        w_nibble     = w_disp[11:8];
        w_dp         = w_disp[18];
        w_upper_zero = (w_disp[15:8] == 8'h00);
      end
      2'd3: begin
        w_nibble     = w_disp[15:12];
        w_dp         = w_disp[19];
        w_upper_zero = (w_disp[15:12] == 4'h0);
      end
      default: ;
    endcase
  end

  fnd_seg_decoder u_dec (
    .i_nibble (w_nibble),
    .o_glyph  (w_glyph)
  );

  assign w_seg = {~w_dp, (i_lz_blank && w_upper_zero) ? 7'h7F : w_glyph};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_DEAD;
      r_cnt        <= '0;
      r_pending    <= '0;
      r_display    <= '0;
      r_digit      <= 2'd0;
      r_position   <= POS_OFF;
      r_segment    <= SEG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      if (i_load) begin
        r_pending <= {i_dp, i_bcd};
      end
      r_frame_done <= (r_digit == 2'd3) && !w_end_show && (w_cnt_inc == C_SLOT_LAST);
      case (r_state)
        ST_DEAD: begin
          r_cnt <= w_cnt_inc;
          if (w_enter_show) begin
            r_state    <= ST_SHOW;
            r_display  <= r_pending;
            r_position <= pos_code(r_digit);
            r_segment  <= w_seg;
          end
        end
        default: begin
          if (w_end_show) begin
            r_state    <= ST_DEAD;
            r_cnt      <= '0;
            r_digit    <= r_digit + 2'd1;
            r_position <= POS_OFF;
            r_segment  <= SEG_OFF;
          end else begin
            r_cnt     <= w_cnt_inc;
            r_segment <= w_seg;
          end
        end
      endcase
    end
  end

  assign o_position   = r_position;
  assign o_segment    = r_segment;
  assign o_digit      = r_digit;
  assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_fnd_scan_controller: scoreboard bench for the FND scan controller. Rev 1.0
// ------------------------------------------------------------------------
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_bcd;
  logic [3:0]  i_dp;
  logic        i_load;
  logic        i_lz_blank;
  logic [3:0]  o_position;
  logic [7:0]  o_segment;
  logic [1:0]  o_digit;
  logic        o_frame_done;

  typedef struct packed {
    logic [1:0] dig;
    logic [3:0] pos;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Active-high {g..a} patterns; inverted when building expectations
  localparam logic [6:0] SEG_HI [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  fnd_scan_controller #(.P_TICK_DIV(8), .P_DEAD_CYC(2)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_bcd        (i_bcd),
    .i_dp         (i_dp),
    .i_load       (i_load),
    .i_lz_blank   (i_lz_blank),
    .o_position   (o_position),
    .o_segment    (o_segment),
    .o_digit      (o_digit),
    .o_frame_done (o_frame_done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [15:0] bcd, input logic [3:0] dp,
                                 input logic lz, input int d);
    exp_t       e;
    logic [15:0] sh;
    logic [3:0] nib;
    logic       blank;
    sh    = bcd >> (4 * d);
    nib   = sh[3:0];
    blank = lz && (d != 0) && (sh == 16'h0000);
    e.dig = 2'(d);
    e.pos = ~(4'b0001 << d);
    e.seg = {~dp[d], blank ? 7'h7F : ~SEG_HI[nib]};
    return e;
  endfunction

  task automatic push_frame(input logic [15:0] bcd, input logic [3:0] dp, input logic lz);
    for (int d = 0; d < 4; d++) sb.push_back(model(bcd, dp, lz, d));
  endtask

  task automatic sync_frame();
    int n = 0;
    while (o_frame_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_total++;
    if (o_frame_done !== 1'b1) $display("FAIL sync_frame frame_done=%b after %0d cycles, need 1", o_frame_done, n);
    else n_pass++;
  endtask

  task automatic load_word(input logic [15:0] bcd, input logic [3:0] dp, input logic lz);
    i_bcd      = bcd;
    i_dp       = dp;
    i_lz_blank = lz;
    i_load     = 1'b1;
    tick();
    i_load     = 1'b0;
  endtask

  // Entered on the first dead cycle of a slot; leaves on the first dead cycle of the next.
  // mode 1 loads nbcd mid-SHOW, mode 2 loads it exactly on the commit edge.
  task automatic check_slot(input int mode, input logic [15:0] nbcd);
    exp_t e;
    n_total++;
    if (o_position !== 4'hF) $display("FAIL dead_a pos=%b need 1111", o_position);
    else n_pass++;
    tick();
    n_total++;
    if (o_position !== 4'hF || o_segment !== 8'hFF)
      $display("FAIL dead_b pos=%b seg=%h need 1111/ff", o_position, o_segment);
    else n_pass++;
    if (mode == 2) begin
      i_bcd  = nbcd;
      i_load = 1'b1;
    end
    tick();
    i_load = 1'b0;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty got pos=%b seg=%h need an expectation", o_position, o_segment);
      return;
    end
    e = sb.pop_front();
    n_total++;
    if (o_digit !== e.dig || o_position !== e.pos || o_segment !== e.seg || o_frame_done !== 1'b0)
      $display("FAIL slot_on got dig=%0d pos=%b seg=%h fd=%b need dig=%0d pos=%b seg=%h fd=0",
               o_digit, o_position, o_segment, o_frame_done, e.dig, e.pos, e.seg);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      if (mode == 1 && k == 1) begin
        i_bcd  = nbcd;
        i_load = 1'b1;
      end
      tick();
      i_load = 1'b0;
    end
    n_total++;
    if (o_position !== e.pos || o_segment !== e.seg)
      $display("FAIL slot_hold d%0d got pos=%b seg=%h need pos=%b seg=%h",
               e.dig, o_position, o_segment, e.pos, e.seg);
    else n_pass++;
    n_total++;
    if (o_frame_done !== (e.dig == 2'd3))
      $display("FAIL frame_done d%0d got %b need %b", e.dig, o_frame_done, (e.dig == 2'd3));
    else n_pass++;
    tick();
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) tick();
    n_total++;
    if (o_position !== 4'hF || o_segment !== 8'hFF || o_digit !== 2'd0 || o_frame_done !== 1'b0)
      $display("FAIL reset_vals got pos=%b seg=%h dig=%0d fd=%b need 1111/ff/0/0",
               o_position, o_segment, o_digit, o_frame_done);
    else n_pass++;
    i_reset = 1'b0;
    tick();
    n_total++;
    if (o_position !== 4'hF || o_segment !== 8'hFF)
      $display("FAIL reset_dead2 got pos=%b seg=%h need 1111/ff", o_position, o_segment);
    else n_pass++;
    tick();
    n_total++;
    if (o_position !== 4'b1110 || o_segment !== 8'hC0 || o_digit !== 2'd0)
      $display("FAIL reset_first_show got pos=%b seg=%h dig=%0d need 1110/c0/0",
               o_position, o_segment, o_digit);
    else n_pass++;
  endtask

  task automatic test_scan_1234();
    int n = 0;
    sync_frame();
    load_word(16'h1234, 4'b0000, 1'b0);
    push_frame(16'h1234, 4'b0000, 1'b0);
    repeat (4) check_slot(0, 16'h0);
    sync_frame();
    tick();
    n = 1;
    n_total++;
    if (o_frame_done !== 1'b0) $display("FAIL frame_pulse_width got fd=%b need 0", o_frame_done);
    else n_pass++;
    while (o_frame_done !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    n_total++;
    if (n != 32) $display("FAIL frame_period got %0d cycles need 32", n);
    else n_pass++;
  endtask

  task automatic test_lz_blank();
    sync_frame();
    load_word(16'h0007, 4'b0000, 1'b1);
    push_frame(16'h0007, 4'b0000, 1'b1);
    repeat (4) check_slot(0, 16'h0);
    sync_frame();
    load_word(16'h0007, 4'b0000, 1'b0);
    push_frame(16'h0007, 4'b0000, 1'b0);
    repeat (4) check_slot(0, 16'h0);
  endtask

  task automatic test_mid_load();
    sync_frame();
    load_word(16'h1234, 4'b0000, 1'b0);
    sb.push_back(model(16'h1234, 4'b0000, 1'b0, 0));
    sb.push_back(model(16'h1234, 4'b0000, 1'b0, 1));
    sb.push_back(model(16'h9999, 4'b0000, 1'b0, 2));
    sb.push_back(model(16'h9999, 4'b0000, 1'b0, 3));
    check_slot(0, 16'h0);
    check_slot(1, 16'h9999);
    check_slot(0, 16'h0);
    check_slot(0, 16'h0);
    sb.push_back(model(16'h9999, 4'b0000, 1'b0, 0));
    sb.push_back(model(16'h5678, 4'b0000, 1'b0, 1));
    sb.push_back(model(16'h5678, 4'b0000, 1'b0, 2));
    sb.push_back(model(16'h5678, 4'b0000, 1'b0, 3));
    check_slot(2, 16'h5678);
    repeat (3) check_slot(0, 16'h0);
  endtask

  task automatic test_abcd_dp();
    sync_frame();
    load_word(16'hABCD, 4'b0001, 1'b0);
    push_frame(16'hABCD, 4'b0001, 1'b0);
    repeat (4) check_slot(0, 16'h0);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    i_lz_blank = 1'b1;
    while (o_position !== 4'b1011 && n < 40) begin
      tick();
      n++;
    end
    n_total++;
    if (o_position !== 4'b1011) $display("FAIL reach_d2 got pos=%b need 1011", o_position);
    else n_pass++;
    repeat (2) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    n_total++;
    if (o_position !== 4'hF || o_segment !== 8'hFF || o_digit !== 2'd0 || o_frame_done !== 1'b0)
      $display("FAIL midreset_vals got pos=%b seg=%h dig=%0d fd=%b need 1111/ff/0/0",
               o_position, o_segment, o_digit, o_frame_done);
    else n_pass++;
    tick();
    n_total++;
    if (o_position !== 4'hF) $display("FAIL midreset_dead2 got pos=%b need 1111", o_position);
    else n_pass++;
    tick();
    n_total++;
    if (o_position !== 4'b1110 || o_segment !== 8'hC0 || o_digit !== 2'd0)
      $display("FAIL midreset_restart got pos=%b seg=%h dig=%0d need 1110/c0/0",
               o_position, o_segment, o_digit);
    else n_pass++;
  endtask

  initial begin
    i_reset    = 1'b1;
    i_bcd      = 16'h0;
    i_dp       = 4'h0;
    i_load     = 1'b0;
    i_lz_blank = 1'b0;
    test_reset();
    test_scan_1234();
    test_lz_blank();
    test_mid_load();
    test_abcd_dp();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
